hook_scene_renderer: RTL

- Pixel-generation stage directly upstream of the VGA timing/output block.
- Consumes the active-area pixel coordinates (curr_x, curr_y) that the output block produces, and returns draw_r/g/b for that pixel.
- Owns the miner hook state machine: horizontal swing, drop on fire, retract.
- Renders sky/earth background, rope and hook square. Positions update once per frame to avoid tearing.

---
 rtl/hook_scene_if.sv | 23 ++
 rtl/hook_scene_renderer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hook_scene_if.sv
// Pixel-coordinate / colour / hook-status bundle between the VGA output block and the renderer.
// master = output block side (drives coordinates and fire), slave = renderer.
interface hook_scene_if;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic        fire;
    logic [3:0]  draw_r;
    logic [3:0]  draw_g;
    logic [3:0]  draw_b;
    logic [10:0] hook_x;
    logic [9:0]  hook_y;
    logic [1:0]  hook_state;

    modport master (
        output curr_x, curr_y, fire,
        input  draw_r, draw_g, draw_b, hook_x, hook_y, hook_state
    );

    modport slave (
        input  curr_x, curr_y, fire,
        output draw_r, draw_g, draw_b, hook_x, hook_y, hook_state
    );
endinterface

// File: rtl/hook_scene_renderer.sv
// Miner hook renderer: swing/drop/retract FSM, positions updated once per frame; draw_* one cycle after coordinate,
// no backpressure. Optional white debug grid under macro HOOK_DEBUG_GRID_EN.
module hook_scene_renderer #(
    parameter int SCREEN_W     = 1280,
    parameter int SCREEN_H     = 800,
    parameter int HOOK_SIZE    = 16,
    parameter int ROPE_Y0      = 64,
    parameter int SWING_MIN_X  = 64,
    parameter int SWING_MAX_X  = 1200,
    parameter int SWING_STEP   = 4,
    parameter int DROP_STEP    = 8,
    parameter int RETRACT_STEP = 4
) (
    input  logic         clk,
    input  logic         rst,
    hook_scene_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_SWING   = 2'b00,
        ST_DROP    = 2'b01,
        ST_RETRACT = 2'b10
    } state_t;

    // All position arithmetic is one bit wider than the coordinate so nothing wraps.
    localparam logic [11:0] X_MIN    = 12'(SWING_MIN_X);
    localparam logic [11:0] X_MAX    = 12'(SWING_MAX_X);
    localparam logic [11:0] X_STEP   = 12'(SWING_STEP);
    localparam logic [11:0] X_SCREEN = 12'(SCREEN_W);
    localparam logic [11:0] X_HALF   = 12'(HOOK_SIZE / 2);
    localparam logic [11:0] X_SIZE   = 12'(HOOK_SIZE);
    localparam logic [10:0] Y_TOP    = 11'(ROPE_Y0);
    localparam logic [10:0] Y_BOT    = 11'(SCREEN_H - HOOK_SIZE);
    localparam logic [10:0] Y_DSTEP  = 11'(DROP_STEP);
    localparam logic [10:0] Y_RSTEP  = 11'(RETRACT_STEP);
    localparam logic [10:0] Y_SIZE   = 11'(HOOK_SIZE);
    localparam logic [9:0]  Y_LAST   = 10'(SCREEN_H - 1);

    state_t      r_state, w_state_nxt;
    logic [10:0] r_hook_x, w_hook_x_nxt;
    logic [9:0]  r_hook_y, w_hook_y_nxt;
    logic        r_dir_left, w_dir_left_nxt;
    logic        r_fire_latch;
    logic [9:0]  r_curr_y_d;
    logic [11:0] r_draw;
    logic [11:0] w_colour;
    logic        w_tick;
    logic [11:0] w_x_ext, w_cx_ext;
    logic [10:0] w_y_ext, w_cy_ext;
    logic        w_is_hook, w_is_rope, w_is_sky;

    assign w_tick   = (r_curr_y_d == Y_LAST) && (bus.curr_y == 10'd0);
    assign w_x_ext  = {1'b0, r_hook_x};
    assign w_y_ext  = {1'b0, r_hook_y};
    assign w_cx_ext = {1'b0, bus.curr_x};
    assign w_cy_ext = {1'b0, bus.curr_y};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SWING;
            r_hook_x   <= 11'(SWING_MIN_X);
            r_hook_y   <= 10'(ROPE_Y0);
            r_dir_left <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hook_x   <= w_hook_x_nxt;
            r_hook_y   <= w_hook_y_nxt;
            r_dir_left <= w_dir_left_nxt;
        end
    end

    // The tick that launches a drop wins over a fire seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fire_latch <= 1'b0;
            r_curr_y_d   <= 10'd0;
        end else begin
            r_curr_y_d <= bus.curr_y;
            if (w_tick && (r_state == ST_SWING) && r_fire_latch)
                r_fire_latch <= 1'b0;
            else if (bus.fire && (r_state == ST_SWING))
                r_fire_latch <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hook_x_nxt   = r_hook_x;
        w_hook_y_nxt   = r_hook_y;
        w_dir_left_nxt = r_dir_left;
        if (w_tick) begin
            case (r_state)
                ST_SWING: begin
                    if (r_fire_latch) begin
                        w_state_nxt = ST_DROP;
                    end else if (!r_dir_left) begin
                        if (w_x_ext + X_STEP >= X_MAX) begin
                            w_hook_x_nxt   = X_MAX[10:0];
                            w_dir_left_nxt = 1'b1;
                        end else begin
                            w_hook_x_nxt = 11'(w_x_ext + X_STEP);
                        end
                    end else begin
                        // x - step <= min, rearranged so the subtraction never goes negative
                        if (w_x_ext <= X_MIN + X_STEP) begin
                            w_hook_x_nxt   = X_MIN[10:0];
                            w_dir_left_nxt = 1'b0;
                        end else begin
                            w_hook_x_nxt = 11'(w_x_ext - X_STEP);
                        end
                    end
                end
                ST_DROP: begin
                    if (w_y_ext + Y_DSTEP >= Y_BOT) begin
                        w_hook_y_nxt = Y_BOT[9:0];
                        w_state_nxt  = ST_RETRACT;
                    end else begin
                        w_hook_y_nxt = 10'(w_y_ext + Y_DSTEP);
                    end
                end
                ST_RETRACT: begin
                    if (w_y_ext <= Y_TOP + Y_RSTEP) begin
                        w_hook_y_nxt = Y_TOP[9:0];
                        w_state_nxt  = ST_SWING;
                    end else begin
                        w_hook_y_nxt = 10'(w_y_ext - Y_RSTEP);
                    end
                end
                default: w_state_nxt = ST_SWING;
            endcase
        end
    end

    always_comb begin
        w_is_hook = (w_cx_ext >= w_x_ext) && (w_cx_ext <= w_x_ext + X_SIZE - 12'd1) &&
                    (w_cy_ext >= w_y_ext) && (w_cy_ext <= w_y_ext + Y_SIZE - 11'd1);
        w_is_rope = ((w_cx_ext == w_x_ext + X_HALF - 12'd1) || (w_cx_ext == w_x_ext + X_HALF)) &&
                    (w_cy_ext >= Y_TOP) && (w_cy_ext < w_y_ext);
        w_is_sky  = (w_cy_ext < Y_TOP);
        w_colour  = 12'h000;
        if (w_cx_ext >= X_SCREEN)
            w_colour = 12'h000;
        else if (w_is_hook)
            w_colour = 12'hFF0;
        else if (w_is_rope)
            w_colour = 12'h840;
`ifdef HOOK_DEBUG_GRID_EN
        else if ((bus.curr_x[5:0] == 6'd0) || (bus.curr_y[5:0] == 6'd0))
            w_colour = 12'hFFF;
`endif
        else if (w_is_sky)
            w_colour = 12'h08F;
        else
            w_colour = 12'h630;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_draw <= 12'h000;
        else
            r_draw <= w_colour;
    end

    assign bus.draw_r     = r_draw[11:8];
    assign bus.draw_g     = r_draw[7:4];
    assign bus.draw_b     = r_draw[3:0];
    assign bus.hook_x     = r_hook_x;
    assign bus.hook_y     = r_hook_y;
    assign bus.hook_state = r_state;

endmodule
